// File: rtl/uart_mmio.sv
// uart_mmio - memory-mapped 8N1 UART for the MEM-stage data bus.
//
// Purpose:
//   Three-register UART (DATA, STATUS, CTRL) with separate TX and RX FIFOs,
//   sticky overrun / framing error flags and a level RX interrupt. The line
//   rate is CLK_FREQ/BAUD clock cycles per bit.
//
// Ports:
//   clk_i    system clock
//   rst_n_i  asynchronous active-low reset
//   cs_i     one-cycle access strobe
//   re_i     read access (qualified by cs_i; ignored when we_i is also set)
//   we_i     write access (qualified by cs_i)
//   addr_i   byte offset: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, others read 0
//   wdata_i  write data
//   rdata_o  combinational read data for addr_i
//   irq_o    registered RX interrupt (rx_ie & rx_not_empty)
//   txd_o    serial output, idle high
//   rxd_i    asynchronous serial input
module uart_mmio #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cs_i,
  input  logic        re_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o,
  output logic        txd_o,
  input  logic        rxd_i
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus decode. A strobe with both re_i and we_i set is treated as a write,
  // so it must never pop the RX FIFO.
  logic sel_data, sel_status, sel_ctrl, wr_acc, rd_acc;
  assign sel_data   = (addr_i == 4'h0);
  assign sel_status = (addr_i == 4'h4);
  assign sel_ctrl   = (addr_i == 4'h8);
  assign wr_acc     = cs_i & we_i;
  assign rd_acc     = cs_i & re_i & ~we_i;

  logic unused_wdata;
  assign unused_wdata = ^wdata_i[31:8];

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TAW:0] tx_wr_ptr, tx_rd_ptr;
  logic         tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]   tx_head;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bits means full.
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full  = (tx_wr_ptr[TAW] != tx_rd_ptr[TAW]) &&
                    (tx_wr_ptr[TAW-1:0] == tx_rd_ptr[TAW-1:0]);
  assign tx_head  = tx_mem[tx_rd_ptr[TAW-1:0]];
  // A write that lands on the same edge as the transmitter's pop is accepted
  // even when full; it overwrites the slot being read out this cycle.
  assign tx_push  = wr_acc & sel_data & (~tx_full | tx_pop);

  // TX FIFO storage needs no reset; only the pointers define its contents.
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr[TAW-1:0]] <= wdata_i[7:0];
  end

  // TX FIFO pointer update.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
    end
  end

  // ----------------------------------------------------------------- TX FSM
  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;

  // TX state and datapath registers. txd_o is registered so the line only
  // changes on bit boundaries.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // TX next state. Every state lasts DIV cycles; the shift register moves
  // right so the next data bit is always at index 1 when a bit ends. STOP
  // chains straight into START when another byte is waiting.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            txd_d      = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign txd_o = txd_q;

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RAW:0] rx_wr_ptr, rx_rd_ptr;
  logic         rx_empty, rx_full, rx_push_req, rx_push, rx_pop;
  logic [7:0]   rx_head;

  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[RAW] != rx_rd_ptr[RAW]) &&
                    (rx_wr_ptr[RAW-1:0] == rx_rd_ptr[RAW-1:0]);
  assign rx_head  = rx_mem[rx_rd_ptr[RAW-1:0]];
  assign rx_pop   = rd_acc & sel_data & ~rx_empty;
  // A CPU pop on the same edge frees a slot, so a received byte is never
  // lost to a full FIFO that is being drained that cycle.
  assign rx_push  = rx_push_req & (~rx_full | rx_pop);

  // RX FIFO storage.
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wr_ptr[RAW-1:0]] <= rx_shift_q;
  end

  // RX FIFO pointer update.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
    end
  end

  // ----------------------------------------------------------------- RX FSM
  logic rx_sync1, rx_sync2, rx_last;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  // All reset to the idle-high line level so reset never looks like an edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_last  <= 1'b1;
    end else begin
      rx_sync1 <= rxd_i;
      rx_sync2 <= rx_sync1;
      rx_last  <= rx_sync2;
    end
  end

  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          frame_err_set;

  // RX state and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX next state. The start bit is checked at its midpoint, after which
  // every sample lands one full bit later, i.e. mid-bit. Leaving STOP right
  // after its sample gives half a bit of slack to catch the next start edge.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_push_req   = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_last && !rx_sync2) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync2) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_bit_d   = '0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync2) rx_push_req   = 1'b1;
          else          frame_err_set = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ------------------------------------------------------ flags, CTRL, IRQ
  logic rx_overrun, frame_err, rx_ie, overrun_set, tx_idle;
  assign overrun_set = rx_push_req & rx_full & ~rx_pop;
  assign tx_idle     = tx_empty & (tx_state_q == TX_IDLE);

  // Sticky flags are write-1-to-clear; a set in the same cycle as a clear
  // wins so no error event is ever lost. irq_o lags the FIFO state by one cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      rx_ie      <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      rx_overrun <= overrun_set |
                    (rx_overrun & ~(wr_acc & sel_status & wdata_i[2]));
      frame_err  <= frame_err_set |
                    (frame_err & ~(wr_acc & sel_status & wdata_i[4]));
      if (wr_acc && sel_ctrl) rx_ie <= wdata_i[0];
      irq_o <= rx_ie & ~rx_empty;
    end
  end

  // Read mux, purely combinational on addr_i and current state.
  always_comb begin
    rdata_o = '0;
    if (sel_data) begin
      if (!rx_empty) rdata_o = {24'b0, rx_head};
    end else if (sel_status) begin
      rdata_o = {27'b0, frame_err, tx_idle, rx_overrun, ~rx_empty, ~tx_full};
    end else if (sel_ctrl) begin
      rdata_o = {31'b0, rx_ie};
    end
  end

endmodule
